temporizador_acao: RTL

- Consumer of the speed-select button block. Reads the 2-bit speed code {chave_1, chave_0} and the restart pulse reset_contagem_botao, both generated in the clk_botao domain.
- Produces a periodic one-cycle action strobe passo at the selected rate.
- Steps the toy's action sequencer, whose output is acao. acao drives the motor/LED decoding downstream.

---
 rtl/temporizador_acao.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/temporizador_acao.sv
// temporizador_acao: periodic action strobe and toy action sequencer.
// Synchronizes the speed code and the restart request coming from the button
// clock domain, times the selected period and steps the action sequence.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// PARADO   | stopped; left after the first passo, entered only by reset
// FRENTE_A | forward, on the way to the left turn
// ESQUERDA | turning left
// FRENTE_B | forward, on the way to the right turn
// DIREITA  | turning right; next is FRENTE_A, closing the loop

module temporizador_acao #(
  parameter int PERIODO_0 = 50000000,
  parameter int PERIODO_1 = 25000000,
  parameter int PERIODO_2 = 12500000,
  parameter int PERIODO_3 = 6250000,
  parameter int LARGURA   = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chave_0,
  input  logic       chave_1,
  input  logic       reset_contagem_botao,
  input  logic       habilita,
  output logic       passo,
  output logic [1:0] acao,
  output logic [1:0] velocidade
);

  typedef enum logic [2:0] {
    PARADO   = 3'd0,
    FRENTE_A = 3'd1,
    ESQUERDA = 3'd2,
    FRENTE_B = 3'd3,
    DIREITA  = 3'd4
  } estado_t;

  // Terminal-count values (period minus one) for each speed code.
  localparam logic [LARGURA-1:0] LIMITE_0 = LARGURA'(PERIODO_0 - 1);
  localparam logic [LARGURA-1:0] LIMITE_1 = LARGURA'(PERIODO_1 - 1);
  localparam logic [LARGURA-1:0] LIMITE_2 = LARGURA'(PERIODO_2 - 1);
  localparam logic [LARGURA-1:0] LIMITE_3 = LARGURA'(PERIODO_3 - 1);

  logic [1:0]         chave_s1_q, chave_s1_d;
  logic [1:0]         chave_s2_q, chave_s2_d;
  logic               rcb_s1_q, rcb_s1_d;
  logic               rcb_s2_q, rcb_s2_d;
  logic               rcb_s3_q, rcb_s3_d;
  logic [LARGURA-1:0] contador_q, contador_d;
  logic               passo_q, passo_d;
  estado_t            estado_q, estado_d;
  logic [1:0]         acao_q, acao_d;

  logic               rst_int;
  logic [LARGURA-1:0] limite;

  // Synchronizer inputs: two stages for the speed code, three for the restart
  // request so its rising edge can be detected in the clk domain.
  always_comb begin
    chave_s1_d = {chave_1, chave_0};
    chave_s2_d = chave_s1_q;
    rcb_s1_d   = reset_contagem_botao;
    rcb_s2_d   = rcb_s1_q;
    rcb_s3_d   = rcb_s2_q;
  end

  // One-cycle restart pulse per rising edge, however long the request is held.
  assign rst_int = rcb_s2_q & ~rcb_s3_q;

  // Terminal count follows the synchronized code immediately.
  always_comb begin
    limite = LIMITE_0;
    case (chave_s2_q)
      2'b00:   limite = LIMITE_0;
      2'b01:   limite = LIMITE_1;
      2'b10:   limite = LIMITE_2;
      default: limite = LIMITE_3;
    endcase
  end

  // Period counter: restart beats enable, enable beats terminal count. The
  // >= compare lets a shortened period fire at once instead of wrapping.
  always_comb begin
    contador_d = contador_q;
    passo_d    = 1'b0;
    if (rst_int) begin
      contador_d = '0;
    end else if (!habilita) begin
      contador_d = contador_q;
    end else if (contador_q >= limite) begin
      contador_d = '0;
      passo_d    = 1'b1;
    end else begin
      contador_d = contador_q + 1'b1;
    end
  end

  // Sequencer next state; acao is decoded from the next state and registered
  // so it changes on the edge right after passo.
  always_comb begin
    estado_d = estado_q;
    if (passo_q) begin
      case (estado_q)
        PARADO:   estado_d = FRENTE_A;
        FRENTE_A: estado_d = ESQUERDA;
        ESQUERDA: estado_d = FRENTE_B;
        FRENTE_B: estado_d = DIREITA;
        DIREITA:  estado_d = FRENTE_A;
        default:  estado_d = FRENTE_A;
      endcase
    end
    acao_d = 2'b00;
    case (estado_d)
      PARADO:   acao_d = 2'b00;
      FRENTE_A: acao_d = 2'b01;
      ESQUERDA: acao_d = 2'b10;
      FRENTE_B: acao_d = 2'b01;
      DIREITA:  acao_d = 2'b11;
      default:  acao_d = 2'b00;
    endcase
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chave_s1_q <= 2'b00;
      chave_s2_q <= 2'b00;
      rcb_s1_q   <= 1'b0;
      rcb_s2_q   <= 1'b0;
      rcb_s3_q   <= 1'b0;
      contador_q <= '0;
      passo_q    <= 1'b0;
      estado_q   <= PARADO;
      acao_q     <= 2'b00;
    end else begin
      chave_s1_q <= chave_s1_d;
      chave_s2_q <= chave_s2_d;
      rcb_s1_q   <= rcb_s1_d;
      rcb_s2_q   <= rcb_s2_d;
      rcb_s3_q   <= rcb_s3_d;
      contador_q <= contador_d;
      passo_q    <= passo_d;
      estado_q   <= estado_d;
      acao_q     <= acao_d;
    end
  end

  assign passo      = passo_q;
  assign acao       = acao_q;
  assign velocidade = chave_s2_q;

endmodule
